dc_reject_sched: RTL and testbench

DC_REJECT_SCHED -- requirements
Module: dc_reject_sched

---
 rtl/dc_reject_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/dc_reject_sched.sv | 160 ++++++++++++++++
 tb/tb_dc_reject_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_reject_pkg.sv
// ============================================================================
// Module      : dc_reject_pkg
// Description : Shared FSM encodings and channel-index width helper for the
//               scheduled DC-reject filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dc_reject_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;

    // A single channel still needs a 1-bit index to keep port widths legal.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot arbiter; the search starts one past the
//               last granted requester and the pointer only moves on a grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import dc_reject_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW     = ch_idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IW'((int'(last_q) + 1 + i) % NUM_REQ);
            if (!w_found && en && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
        last_d = w_found ? grant_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dc_reject_sched.sv
// ============================================================================
// Module      : dc_reject_sched
// Description : Multi-channel DC-reject filter sharing one datapath through a
//               three-state IDLE/CALC/ACC schedule with round-robin intake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dc_reject_sched
    import dc_reject_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SIGNAL_WIDTH = 16,
    parameter int ALPHA_WIDTH  = 24,
    localparam int CHW         = ch_idx_w(NUM_CH)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ALPHA_WIDTH-1:0]         alpha,
    input  logic [NUM_CH*SIGNAL_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH-1:0]              clr_ch,
    output logic [SIGNAL_WIDTH-1:0]        out,
    output logic [CHW-1:0]                 out_ch,
    output logic                           out_valid,
    output logic                           busy
);

    localparam int AW    = ALPHA_WIDTH;
    localparam int SW    = SIGNAL_WIDTH;
    localparam int SHIFT = AW - SW;

    logic [1:0]          state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [AW-1:0]       x_q, x_d;
    logic [AW-1:0]       diff_q, diff_d;
    logic [2*AW-1:0]     prod_q, prod_d;
    logic [AW-1:0]       x_hist_q [NUM_CH];
    logic [AW-1:0]       x_hist_d [NUM_CH];
    logic [AW-1:0]       y_hist_q [NUM_CH];
    logic [AW-1:0]       y_hist_d [NUM_CH];
    logic [SW-1:0]       out_q, out_d;
    logic [CHW-1:0]      out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;

    logic [NUM_CH-1:0]   w_grant;
    logic [CHW-1:0]      w_grant_idx;
    logic                w_arb_en;
    logic [AW-1:0]       w_x_in;
    logic [AW-1:0]       w_y_hist;
    logic [AW-1:0]       w_prod_scaled;
    logic [AW-1:0]       w_y;
    logic                w_prod_unused;

    assign w_arb_en = (state_q == ST_IDLE) && aresetn;

    rr_arbiter #(
        .NUM_REQ (NUM_CH)
    ) u_arb (
        .clk       (aclk),
        .rst_n     (aresetn),
        .req       (in_valid),
        .en        (w_arb_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_x_in   = {in_data[w_grant_idx*SW +: SW], {SHIFT{1'b0}}};
    assign w_y_hist = y_hist_q[ch_q];

    // Low AW bits of (prod >>> (AW-1)); the dropped bits never reach y.
    assign w_prod_scaled = prod_q[2*AW-2 -: AW];
    assign w_prod_unused = &{prod_q[2*AW-1], prod_q[AW-2:0]};
    assign w_y           = diff_q + w_prod_scaled;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        x_d         = x_q;
        diff_d      = diff_q;
        prod_d      = prod_q;
        x_hist_d    = x_hist_q;
        y_hist_d    = y_hist_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|w_grant) begin
                    ch_d    = w_grant_idx;
                    x_d     = w_x_in;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                diff_d  = x_q - x_hist_q[ch_q];
                prod_d  = {{AW{w_y_hist[AW-1]}}, w_y_hist} * {{AW{alpha[AW-1]}}, alpha};
                state_d = ST_ACC;
            end
            ST_ACC: begin
                x_hist_d[ch_q] = x_q;
                y_hist_d[ch_q] = w_y;
                out_d          = w_y[AW-1 -: SW];
                out_ch_d       = ch_q;
                out_valid_d    = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear beats a same-cycle write-back; out still reports the new y.
        for (int k = 0; k < NUM_CH; k++) begin
            if (clr_ch[k]) begin
                x_hist_d[k] = '0;
                y_hist_d[k] = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            x_q         <= '0;
            diff_q      <= '0;
            prod_q      <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                x_hist_q[k] <= '0;
                y_hist_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            diff_q      <= diff_d;
            prod_q      <= prod_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            x_hist_q    <= x_hist_d;
            y_hist_q    <= y_hist_d;
        end
    end

    assign in_ready  = w_grant;
    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dc_reject_sched.sv
// ============================================================================
// Module      : tb_dc_reject_sched
// Description : Directed, table-driven self-checking bench for dc_reject_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dc_reject_sched;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [23:0] alpha = '0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [3:0]  clr_ch = '0;
    logic [15:0] out;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    dc_reject_sched #(
        .NUM_CH       (4),
        .SIGNAL_WIDTH (16),
        .ALPHA_WIDTH  (24)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .alpha     (alpha),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clr_ch    (clr_ch),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        logic [23:0] alpha;
        int          clr_at;   // 0 none, 1 pulse in CALC, 2 pulse in ACC
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn  = 1'b0;
        in_valid = '0;
        clr_ch   = '0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic txn(input vec_t v, input string name);
        logic [3:0] oh;
        bit         got;
        oh = 4'b0001 << v.ch;
        @(posedge aclk);
        #1;
        alpha                  = v.alpha;
        in_data[v.ch*16 +: 16] = v.data;
        in_valid               = oh;
        got                    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge aclk);
            if (in_ready != 4'b0000) got = 1'b1;
        end
        chk({name, "_grant_seen"}, 32'(got), 32'd1);
        if (!got) begin
            in_valid = '0;
            return;
        end
        chk({name, "_grant"}, 32'(in_ready), 32'(oh));
        @(posedge aclk);
        #1;
        in_valid = '0;
        if (v.clr_at == 1) clr_ch = oh;
        @(negedge aclk);
        chk({name, "_ov_t1"}, 32'(out_valid), 32'd0);
        chk({name, "_busy_t1"}, 32'(busy), 32'd1);
        @(posedge aclk);
        #1;
        clr_ch = '0;
        if (v.clr_at == 2) clr_ch = oh;
        @(negedge aclk);
        chk({name, "_ov_t2"}, 32'(out_valid), 32'd0);
        @(posedge aclk);
        #1;
        clr_ch = '0;
        @(negedge aclk);
        chk({name, "_ov_t3"}, 32'(out_valid), 32'd1);
        chk({name, "_out"}, 32'(out), 32'(v.exp));
        chk({name, "_out_ch"}, 32'(out_ch), 32'(v.ch));
    endtask

    function automatic longint wrap24(input longint v);
        longint m;
        m = v & 64'hFF_FFFF;
        if (m >= 64'h80_0000) m = m - 64'h100_0000;
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rr_ch  [6];
        logic [15:0] rr_out [6];
        bit          seen;
        vec_t        v;
        longint      xd, yd, x, diff, prod, y;

        vecs[0]  = '{2'd0, 16'h4000, 24'h400000, 0, 16'h4000};
        vecs[1]  = '{2'd0, 16'h4000, 24'h400000, 0, 16'h2000};
        vecs[2]  = '{2'd0, 16'h4000, 24'h400000, 0, 16'h1000};
        vecs[3]  = '{2'd0, 16'h4000, 24'h400000, 0, 16'h0800};
        vecs[4]  = '{2'd1, 16'h1000, 24'h000000, 0, 16'h1000};
        vecs[5]  = '{2'd1, 16'h3000, 24'h000000, 0, 16'h2000};
        vecs[6]  = '{2'd2, 16'h1000, 24'h400000, 2, 16'h1000};
        vecs[7]  = '{2'd2, 16'h4000, 24'h400000, 0, 16'h4000};
        vecs[8]  = '{2'd3, 16'h2000, 24'h400000, 0, 16'h2000};
        vecs[9]  = '{2'd3, 16'h2000, 24'h400000, 1, 16'h1000};
        vecs[10] = '{2'd3, 16'h2000, 24'h400000, 0, 16'h0800};

        // Reset state, with requests pending to show in_ready stays low.
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        in_valid = 4'hF;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        in_valid = '0;
        aresetn  = 1'b1;

        for (int i = 0; i < 11; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Round robin with every channel requesting continuously.
        do_reset();
        rr_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_out = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0000, 16'h0000};
        alpha    = '0;
        in_data  = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        in_valid = 4'hF;
        #1;
        for (int i = 0; i < 10 && in_ready == 4'b0000; i++) @(negedge aclk);
        for (int g = 0; g < 6; g++) begin
            chk($sformatf("rr%0d_grant", g), 32'(in_ready), 32'(4'b0001 << rr_ch[g]));
            @(negedge aclk);
            @(negedge aclk);
            chk($sformatf("rr%0d_ov_early", g), 32'(out_valid), 32'd0);
            @(negedge aclk);
            chk($sformatf("rr%0d_ov", g), 32'(out_valid), 32'd1);
            chk($sformatf("rr%0d_out_ch", g), 32'(out_ch), 32'(rr_ch[g]));
            chk($sformatf("rr%0d_out", g), 32'(out), 32'(rr_out[g]));
        end
        in_valid = '0;

        // Reset during CALC: pointer last granted ch1, so the pending grant goes to ch2.
        repeat (3) @(negedge aclk);
        in_valid = 4'b0101;
        #1;
        chk("prerst_grant", 32'(in_ready), 32'b0100);
        @(posedge aclk);
        #1;
        in_valid = '0;
        #1;
        aresetn  = 1'b0;
        in_valid = 4'b0101;
        @(negedge aclk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        in_valid = '0;
        aresetn  = 1'b1;
        seen     = 1'b0;
        repeat (6) begin
            @(negedge aclk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("postrst_no_ov", 32'(seen), 32'd0);
        in_valid = 4'b0101;
        #1;
        chk("postrst_grant", 32'(in_ready), 32'b0001);
        in_valid = '0;

        // Near-unity alpha with full-scale alternating input; wrapped arithmetic.
        do_reset();
        xd = 0;
        yd = 0;
        for (int i = 0; i < 6; i++) begin
            v.ch     = 2'd3;
            v.data   = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            v.alpha  = 24'h7FFFFF;
            v.clr_at = 0;
            x    = longint'($signed(v.data)) * 256;
            diff = wrap24(x - xd);
            prod = yd * longint'($signed(v.alpha));
            y    = wrap24(diff + (prod >>> 23));
            v.exp = 16'((y >>> 8) & 64'hFFFF);
            xd   = x;
            yd   = y;
            txn(v, $sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d_known", i), 32'($isunknown({out, out_ch, out_valid})), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
